stash_scan_table_drain: RTL and testbench

Next-generation stash scan table for the Path ORAM stash, parametrised in tree depth (ORAML), bucket size (ORAMZ) and stash address width.
- Per-access function is unchanged: decides greedily, per scanned stash entry, the deepest non-full bucket on the current path and records the stash address in a path-ordered slot table.
- New: an internal drain sequencer streams the table out over a valid/ready interface, clearing each slot as it is read. No external DMA address generation or per-access reset pulse is needed.
- Sits between the stash scan FSM and the path writeback datapath.

---
 rtl/stash_scan_table_drain_if.sv | 46 ++++
 rtl/stash_scan_table_drain.sv | 189 ++++++++++++++++++
 tb/tb_stash_scan_table_drain.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/stash_scan_table_drain_if.sv
// Scan and drain channels of the stash scan table.
// slave is the table side, master is the scan FSM / writeback side.
interface stash_scan_table_drain_if #(
    parameter int ORAML        = 4,
    parameter int ORAMZ        = 4,
    parameter int StashEAWidth = 8
);
    localparam int TAWidth = $clog2((ORAML + 1) * ORAMZ + 1);

    logic                    ResetDone;
    logic [ORAML-1:0]        CurrentLeaf;
    logic                    CurrentLeafValid;
    logic [ORAML-1:0]        InScanLeaf;
    logic [StashEAWidth-1:0] InScanSAddr;
    logic                    InScanValid;
    logic                    InScanReady;
    logic [StashEAWidth-1:0] OutScanSAddr;
    logic                    OutScanAccepted;
    logic                    OutScanValid;
    logic [TAWidth-1:0]      OutFillCount;
    logic                    DrainStart;
    logic [StashEAWidth-1:0] OutDrainData;
    logic                    OutDrainValid;
    logic                    OutDrainReady;
    logic                    DrainDone;

    modport slave (
        input  CurrentLeaf, CurrentLeafValid,
        input  InScanLeaf, InScanSAddr, InScanValid,
        input  DrainStart, OutDrainReady,
        output ResetDone, InScanReady,
        output OutScanSAddr, OutScanAccepted, OutScanValid,
        output OutFillCount, OutDrainData, OutDrainValid,
        output DrainDone
    );

    modport master (
        output CurrentLeaf, CurrentLeafValid,
        output InScanLeaf, InScanSAddr, InScanValid,
        output DrainStart, OutDrainReady,
        input  ResetDone, InScanReady,
        input  OutScanSAddr, OutScanAccepted, OutScanValid,
        input  OutFillCount, OutDrainData, OutDrainValid,
        input  DrainDone
    );
endinterface

// File: rtl/stash_scan_table_drain.sv
// Path ORAM stash scan table: greedy deepest-bucket placement of
// scanned stash entries, then a self-clearing valid/ready drain.
module stash_scan_table_drain #(
    parameter int ORAML        = 4,
    parameter int ORAMZ        = 4,
    parameter int StashEAWidth = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    stash_scan_table_drain_if.slave Bus
);
    localparam int LP1       = ORAML + 1;
    localparam int N         = LP1 * ORAMZ;
    localparam int BCWidth   = $clog2(ORAMZ + 1);
    localparam int TAWidth   = $clog2(N + 1);
    localparam int LvWidth   = $clog2(LP1);
    localparam int RamAWidth = $clog2(N);

    localparam logic [StashEAWidth-1:0] SNULL = '1;
    localparam logic [TAWidth-1:0]      TAN   = TAWidth'(N);
    localparam logic [BCWidth-1:0]      FullCount = BCWidth'(ORAMZ);

    typedef enum logic [1:0] {StInit, StScan, StDrain} stateT;

    stateT state;
    stateT nextState;

    logic [TAWidth-1:0]      initCount;
    logic [BCWidth-1:0]      levelCount [LP1];
    logic [TAWidth-1:0]      fillCount;
    logic [TAWidth-1:0]      drainPtr;
    logic [StashEAWidth-1:0] drainData;
    logic                    drainValid;
    logic [StashEAWidth-1:0] slotRam [N];

    logic                    commonRun;
    logic                    hit;
    logic [LvWidth-1:0]      hitLevel;
    logic                    scanFire;
    logic                    accept;
    logic [TAWidth-1:0]      slotAddr;
    logic                    drainIssue;
    logic                    drainLast;

    logic                    wrEn;
    logic [TAWidth-1:0]      wrAddr;
    logic [StashEAWidth-1:0] wrData;

    // Deepest common level that still has a free slot; common levels
    // form a prefix from the root, so a running match flag suffices.
    always_comb begin
        commonRun = 1'b1;
        hit       = 1'b0;
        hitLevel  = '0;
        if (levelCount[0] != FullCount) begin
            hit = 1'b1;
        end
        for (int k = 1; k < LP1; k++) begin
            commonRun = commonRun &
                (Bus.InScanLeaf[k-1] == Bus.CurrentLeaf[k-1]);
            if (commonRun && levelCount[k] != FullCount) begin
                hit      = 1'b1;
                hitLevel = LvWidth'(k);
            end
        end
    end

    // Scan and drain control strobes.
    always_comb begin
        scanFire   = (state == StScan) & Bus.InScanValid &
                     Bus.CurrentLeafValid;
        accept     = scanFire & hit;
        slotAddr   = TAWidth'(hitLevel) * TAWidth'(ORAMZ) +
                     TAWidth'(levelCount[hitLevel]);
        drainIssue = (state == StDrain) && (drainPtr != TAN) &&
                     (!drainValid || Bus.OutDrainReady);
        drainLast  = (state == StDrain) && (drainPtr == TAN) &&
                     drainValid && Bus.OutDrainReady;
    end

    // Single RAM write port shared by init fill, scan insert and drain clear.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = SNULL;
        unique case (state)
            StInit: begin
                if (initCount != TAN) begin
                    wrEn   = 1'b1;
                    wrAddr = initCount;
                end
            end
            StScan: begin
                if (accept) begin
                    wrEn   = 1'b1;
                    wrAddr = slotAddr;
                    wrData = Bus.InScanSAddr;
                end
            end
            StDrain: begin
                if (drainIssue) begin
                    wrEn   = 1'b1;
                    wrAddr = drainPtr;
                end
            end
            default: ;
        endcase
    end

    // Slot table storage, no reset: INIT rewrites every slot.
    always_ff @(posedge Clock) begin
        if (wrEn) begin
            slotRam[wrAddr[RamAWidth-1:0]] <= wrData;
        end
    end

    // Drain read side: read-first output register and read pointer.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            drainData  <= '0;
            drainValid <= 1'b0;
            drainPtr   <= '0;
        end else if (drainIssue) begin
            drainData  <= slotRam[drainPtr[RamAWidth-1:0]];
            drainValid <= 1'b1;
            drainPtr   <= drainPtr + 1'b1;
        end else if (drainLast) begin
            drainValid <= 1'b0;
            drainPtr   <= '0;
        end
    end

    // Init counter, per-level occupancy and fill count.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            initCount <= '0;
            fillCount <= '0;
            for (int i = 0; i < LP1; i++) begin
                levelCount[i] <= '0;
            end
        end else begin
            if (state == StInit && initCount != TAN) begin
                initCount <= initCount + 1'b1;
            end
            if (drainLast) begin
                fillCount <= '0;
                for (int i = 0; i < LP1; i++) begin
                    levelCount[i] <= '0;
                end
            end else if (accept) begin
                fillCount <= fillCount + 1'b1;
                levelCount[hitLevel] <= levelCount[hitLevel] + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= StInit;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        unique case (state)
            StInit:  if (initCount == TAN) nextState = StScan;
            StScan:  if (Bus.DrainStart)   nextState = StDrain;
            StDrain: if (drainLast)        nextState = StScan;
            default: nextState = StInit;
        endcase
    end

    // Outputs; ResetDone latches by virtue of never re-entering INIT.
    always_comb begin
        Bus.ResetDone       = (state != StInit) || (initCount == TAN);
        Bus.InScanReady     = (state == StScan);
        Bus.OutScanValid    = Bus.InScanValid & (state == StScan);
        Bus.OutScanAccepted = accept;
        Bus.OutScanSAddr    = Bus.OutScanValid ? Bus.InScanSAddr : '0;
        Bus.OutFillCount    = fillCount;
        Bus.OutDrainData    = drainData;
        Bus.OutDrainValid   = drainValid;
        Bus.DrainDone       = drainLast;
    end
endmodule

// File: tb/tb_stash_scan_table_drain.sv
// Randomized bench for stash_scan_table_drain against a
// level-occupancy reference model of the path slot table.
module tb_stash_scan_table_drain;
    localparam int L   = 3;
    localparam int Z   = 2;
    localparam int SW  = 4;
    localparam int LP1 = L + 1;
    localparam int N   = LP1 * Z;
    localparam logic [SW-1:0] SNULL = '1;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    int nChecks = 0;
    int nErrors = 0;

    logic [SW-1:0] modelTab [N];
    int            modelCnt [LP1];
    int            modelFill;
    logic [L-1:0]  curLeaf;

    always #5 Clock = ~Clock;

    stash_scan_table_drain_if #(
        .ORAML(L), .ORAMZ(Z), .StashEAWidth(SW)
    ) bus ();

    stash_scan_table_drain #(
        .ORAML(L), .ORAMZ(Z), .StashEAWidth(SW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Bus(bus)
    );

    task automatic checkEq(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < N; i++) modelTab[i] = SNULL;
        for (int i = 0; i < LP1; i++) modelCnt[i] = 0;
        modelFill = 0;
    endtask

    task automatic releaseAndInit(input string tag);
        int cycles = 0;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checkEq({tag, "_doneLow"}, bus.ResetDone, 0);
        while (!bus.ResetDone && cycles < 50) begin
            @(negedge Clock);
            cycles++;
        end
        checkEq({tag, "_cycles"}, cycles, N);
        @(negedge Clock);
        checkEq({tag, "_scanReady"}, bus.InScanReady, 1);
        checkEq({tag, "_fill"}, bus.OutFillCount, 0);
        modelClear();
    endtask

    task automatic scanOne(input logic [L-1:0] leaf,
                           input logic [SW-1:0] addr,
                           input bit valid);
        int d;
        int lvl;
        @(negedge Clock);
        bus.InScanLeaf  = leaf;
        bus.InScanSAddr = addr;
        bus.InScanValid = valid;
        #1;
        if (valid) begin
            d = 0;
            while (d < L && leaf[d] == curLeaf[d]) d++;
            lvl = -1;
            for (int l = d; l >= 0; l--)
                if (lvl < 0 && modelCnt[l] < Z) lvl = l;
            checkEq("scanValid", bus.OutScanValid, 1);
            checkEq("scanAccept", bus.OutScanAccepted, int'(lvl >= 0));
            checkEq("scanEcho", bus.OutScanSAddr, addr);
            if (lvl >= 0) begin
                modelTab[lvl * Z + modelCnt[lvl]] = addr;
                modelCnt[lvl]++;
                modelFill++;
            end
        end else begin
            checkEq("idleValid", bus.OutScanValid, 0);
            checkEq("idleAccept", bus.OutScanAccepted, 0);
            checkEq("idleEcho", bus.OutScanSAddr, 0);
        end
        @(posedge Clock);
        #1;
        bus.InScanValid = 1'b0;
        checkEq("fillCount", bus.OutFillCount, modelFill);
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready
    task automatic drainPath(input int mode, input bit poke, input int abortAt);
        logic [SW-1:0] exp [N];
        logic [SW-1:0] held;
        bit rdy;
        bit wasHeld = 0;
        int beats = 0;
        int dones = 0;
        int guard = 0;
        exp = modelTab;
        held = '0;
        @(negedge Clock);
        bus.DrainStart = 1'b1;
        @(negedge Clock);
        bus.DrainStart = 1'b0;
        checkEq("drainScanReady", bus.InScanReady, 0);
        while (beats < N && guard < 200 &&
               !(abortAt > 0 && beats == abortAt)) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 4 == 0) || (guard % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.OutDrainReady = rdy;
            if (poke) begin
                bus.InScanValid = 1'b1;
                bus.InScanLeaf  = L'($urandom);
                bus.InScanSAddr = SW'($urandom);
            end
            #1;
            if (poke) begin
                checkEq("pokeReady", bus.InScanReady, 0);
                checkEq("pokeValid", bus.OutScanValid, 0);
                checkEq("pokeAccept", bus.OutScanAccepted, 0);
            end
            if (wasHeld) begin
                checkEq("holdValid", bus.OutDrainValid, 1);
                checkEq("holdData", bus.OutDrainData, held);
            end
            wasHeld = bus.OutDrainValid && !rdy;
            held = bus.OutDrainData;
            if (bus.OutDrainValid && rdy) begin
                checkEq($sformatf("beat%0d", beats), bus.OutDrainData,
                        exp[beats]);
                beats++;
            end
            if (bus.DrainDone) dones++;
            guard++;
            @(negedge Clock);
        end
        bus.InScanValid = 1'b0;
        if (abortAt > 0 && beats == abortAt) return;
        checkEq("drainBeats", beats, N);
        checkEq("drainDoneCount", dones, 1);
        #1;
        checkEq("postValid", bus.OutDrainValid, 0);
        checkEq("postDone", bus.DrainDone, 0);
        checkEq("postScanReady", bus.InScanReady, 1);
        checkEq("postFill", bus.OutFillCount, 0);
        bus.OutDrainReady = 1'b0;
        modelClear();
    endtask

    initial begin
        logic [L-1:0] lf;
        bus.CurrentLeaf      = '0;
        bus.CurrentLeafValid = 1'b1;
        bus.InScanLeaf       = '0;
        bus.InScanSAddr      = '0;
        bus.InScanValid      = 1'b0;
        bus.DrainStart       = 1'b0;
        bus.OutDrainReady    = 1'b0;
        curLeaf = '0;
        modelClear();

        #12;
        checkEq("rstDone", bus.ResetDone, 0);
        checkEq("rstScanReady", bus.InScanReady, 0);
        checkEq("rstDrainValid", bus.OutDrainValid, 0);
        checkEq("rstDrainDone", bus.DrainDone, 0);
        checkEq("rstFill", bus.OutFillCount, 0);
        releaseAndInit("init");

        drainPath(0, 0, 0);

        curLeaf = 3'b101;
        bus.CurrentLeaf = curLeaf;
        scanOne(3'b101, 4'd1, 1);
        scanOne(3'b101, 4'd2, 1);
        scanOne(3'b101, 4'd3, 1);
        drainPath(0, 0, 0);

        scanOne(3'b100, 4'd5, 1);
        scanOne(3'b100, 4'd6, 1);
        scanOne(3'b100, 4'd7, 1);
        drainPath(1, 0, 0);
        drainPath(2, 0, 0);

        scanOne(3'b001, 4'd9, 1);
        scanOne(3'b101, 4'd4, 1);
        drainPath(2, 1, 0);

        repeat (6) begin
            curLeaf = L'($urandom);
            bus.CurrentLeaf = curLeaf;
            repeat (12) begin
                if ($urandom_range(0, 1) == 1)
                    lf = curLeaf ^ L'(1 << $urandom_range(0, L - 1));
                else
                    lf = L'($urandom);
                scanOne(lf, SW'($urandom), $urandom_range(0, 3) != 0);
            end
            drainPath(2, 0, 0);
        end

        scanOne(curLeaf, 4'd2, 1);
        scanOne(curLeaf, 4'd3, 1);
        drainPath(0, 0, 3);
        Reset = 1'b1;
        #1;
        checkEq("midRstDrainValid", bus.OutDrainValid, 0);
        checkEq("midRstDone", bus.ResetDone, 0);
        checkEq("midRstScanReady", bus.InScanReady, 0);
        checkEq("midRstDrainDone", bus.DrainDone, 0);
        checkEq("midRstFill", bus.OutFillCount, 0);
        bus.OutDrainReady = 1'b0;
        releaseAndInit("reinit");
        drainPath(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
